// File: rtl/pipeline_skid_buffer.sv
// Two-entry skid buffer between pipeline stages: every output comes straight from a
// flop, so s_ready and m_valid never depend combinationally on the opposite handshake.
//
// state | meaning
// EMPTY | nothing buffered, m_valid=0, s_ready=1
// BUSY  | one beat in main, m_valid=1, s_ready=1
// FULL  | main plus an overflow beat in skid, m_valid=1, s_ready=0
module pipeline_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             s_acc;
  logic             m_acc;

  assign s_acc  = s_valid & s_ready;
  assign m_acc  = m_valid & m_ready;
  assign m_data = main_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      m_valid <= 1'b0;
      s_ready <= 1'b0;
      count   <= 2'd0;
    end else if (flush) begin
      // data registers are left alone; their contents are meaningless once EMPTY
      state   <= EMPTY;
      m_valid <= 1'b0;
      s_ready <= 1'b1;
      count   <= 2'd0;
    end else begin
      case (state)
        EMPTY: begin
          s_ready <= 1'b1;
          if (s_acc) begin
            main_q  <= s_data;
            state   <= BUSY;
            m_valid <= 1'b1;
            count   <= 2'd1;
          end
        end
        BUSY: begin
          if (s_acc && !m_acc) begin
            skid_q  <= s_data;
            state   <= FULL;
            s_ready <= 1'b0;
            count   <= 2'd2;
          end else if (s_acc && m_acc) begin
            main_q <= s_data;
          end else if (!s_acc && m_acc) begin
            state   <= EMPTY;
            m_valid <= 1'b0;
            count   <= 2'd0;
          end
        end
        FULL: begin
          // s side is ignored here: s_ready is already low
          if (m_acc) begin
            main_q  <= skid_q;
            state   <= BUSY;
            s_ready <= 1'b1;
            count   <= 2'd1;
          end
        end
        default: begin
          state   <= EMPTY;
          m_valid <= 1'b0;
          s_ready <= 1'b1;
          count   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_skid_buffer.sv
// Bench for pipeline_skid_buffer: a negedge monitor keeps a reference queue of accepted
// beats and checks every m-side handshake and the buffered count against it.
module tb_pipeline_skid_buffer;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] count;

  int         n_cmp;
  int         n_err;
  logic [7:0] q[$];
  logic [7:0] exp_beat;

  pipeline_skid_buffer #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after posedge, so at negedge both inputs and outputs are settled
  // and describe exactly the handshakes of the coming edge.
  always @(negedge clk) begin
    if (reset) begin
      n_cmp++;
      if (int'(count) != q.size()) begin
        n_err++;
        $display("FAIL count_model: got %0d expected %0d", count, q.size());
      end
      n_cmp++;
      if (m_valid !== (q.size() != 0)) begin
        n_err++;
        $display("FAIL m_valid_model: got %0b expected %0b", m_valid, q.size() != 0);
      end
      if (m_valid && m_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL beat_extra: got %0h expected no beat", m_data);
        end else begin
          exp_beat = q.pop_front();
          if (m_data !== exp_beat) begin
            n_err++;
            $display("FAIL beat_order: got %0h expected %0h", m_data, exp_beat);
          end
        end
      end
      if (flush) q.delete();
      else if (s_valid && s_ready) q.push_back(s_data);
    end
  end

  always @(negedge reset) q.delete();

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0 || count !== 2'd0 || m_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_state: got mv=%0b sr=%0b cnt=%0d md=%0h expected 0 0 0 00",
               m_valid, s_ready, count, m_data);
    end
    tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: got %0b expected 1", s_ready);
    end
  endtask

  task automatic test_single_beat();
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h5A;
    tick();
    s_valid = 1'b0;
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== 8'h5A || count !== 2'd1) begin
      n_err++;
      $display("FAIL single_out: got mv=%0b md=%0h cnt=%0d expected 1 5a 1", m_valid, m_data, count);
    end
    tick();
    n_cmp++;
    if (m_valid !== 1'b0 || count !== 2'd0) begin
      n_err++;
      $display("FAIL single_drain: got mv=%0b cnt=%0d expected 0 0", m_valid, count);
    end
  endtask

  task automatic test_stream();
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      tick();
      n_cmp++;
      if (s_ready !== 1'b1 || m_valid !== 1'b1 || m_data !== 8'(i)) begin
        n_err++;
        $display("FAIL stream_beat: got sr=%0b mv=%0b md=%0h expected 1 1 %0h",
                 s_ready, m_valid, m_data, i);
      end
    end
    s_valid = 1'b0;
    tick();
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL stream_end: got mv=%0b expected 0", m_valid);
    end
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hA1;
    tick();
    s_data = 8'hA2;
    tick();
    n_cmp++;
    if (count !== 2'd2 || s_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_full: got cnt=%0d sr=%0b expected 2 0", count, s_ready);
    end
    s_data = 8'hA3;
    tick();
    n_cmp++;
    if (count !== 2'd2 || m_data !== 8'hA1) begin
      n_err++;
      $display("FAIL bp_hold: got cnt=%0d md=%0h expected 2 a1", count, m_data);
    end
    m_ready = 1'b1;
    tick();
    n_cmp++;
    if (m_data !== 8'hA2 || s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: got md=%0h sr=%0b expected a2 1", m_data, s_ready);
    end
    tick();
    s_valid = 1'b0;
    n_cmp++;
    if (m_data !== 8'hA3 || m_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_third: got md=%0h mv=%0b expected a3 1", m_data, m_valid);
    end
    tick();
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain: got mv=%0b expected 0", m_valid);
    end
  endtask

  task automatic test_flush();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h11;
    tick();
    s_data = 8'h22;
    tick();
    flush  = 1'b1;
    s_data = 8'h33;
    tick();
    flush   = 1'b0;
    s_valid = 1'b0;
    n_cmp++;
    if (count !== 2'd0 || m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_full: got cnt=%0d mv=%0b expected 0 0", count, m_valid);
    end
    m_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_leak: got mv=%0b md=%0h expected no beat", m_valid, m_data);
    end
    // flush while the current beat is being taken downstream
    s_valid = 1'b1;
    s_data  = 8'h44;
    tick();
    flush  = 1'b1;
    s_data = 8'h55;
    tick();
    flush   = 1'b0;
    s_valid = 1'b0;
    n_cmp++;
    if (count !== 2'd0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_busy: got cnt=%0d mv=%0b sr=%0b expected 0 0 1", count, m_valid, s_ready);
    end
  endtask

  task automatic test_async_reset();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hC1;
    tick();
    s_data = 8'hC2;
    tick();
    s_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0 || count !== 2'd0 || m_data !== 8'h00) begin
      n_err++;
      $display("FAIL async_reset: got mv=%0b sr=%0b cnt=%0d md=%0h expected 0 0 0 00",
               m_valid, s_ready, count, m_data);
    end
    tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL async_recover: got sr=%0b mv=%0b expected 1 0", s_ready, m_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      s_data  = 8'(i);
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    tick();
    tick();
    n_cmp++;
    if (q.size() != 0 || m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL random_drain: got left=%0d mv=%0b expected 0 0", q.size(), m_valid);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b0;
    flush   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    m_ready = 1'b0;
    test_reset();
    test_single_beat();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
